// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one shared add/sub/shift datapath
// driven by a three-state controller, one Booth iteration per clock.
module booth_seq_ctrl #(
    parameter int D_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [D_SIZE-1:0]     M,
    input  logic [D_SIZE-1:0]     Q,
    output logic                  busy,
    output logic                  done,
    output logic [2*D_SIZE-1:0]   Product
);

    localparam int CW = $clog2(D_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // A and Mreg carry one guard bit so that -M is exact for the most negative M.
    logic [D_SIZE:0]        r_a;
    logic [D_SIZE:0]        r_m;
    logic [D_SIZE-1:0]      r_q;
    logic                   r_q_1;
    logic [CW-1:0]          r_count;
    logic [2*D_SIZE-1:0]    r_product;

    logic [D_SIZE:0]        w_sum;
    logic [D_SIZE:0]        w_a_nxt;
    logic [D_SIZE-1:0]      w_q_nxt;
    logic                   w_last;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_count == CW'(1));

    // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign Product = r_product;

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q_1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    // Arithmetic right shift of {A', Qreg, q_1}; the q_1 bit falls out as r_q[0].
    assign w_a_nxt = {w_sum[D_SIZE], w_sum[D_SIZE:1]};
    assign w_q_nxt = {w_sum[0], r_q[D_SIZE-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= {M[D_SIZE-1], M};
                        r_a     <= '0;
                        r_q     <= Q;
                        r_q_1   <= 1'b0;
                        r_count <= CW'(D_SIZE);
                    end
                end
                S_CALC: begin
                    r_a     <= w_a_nxt;
                    r_q     <= w_q_nxt;
                    r_q_1   <= r_q[0];
                    r_count <= r_count - CW'(1);
                    if (w_last) begin
                        r_product <= {w_a_nxt[D_SIZE-1:0], w_q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed corners, exhaustive sweep and
// randomized operand/start noise against an integer-multiply reference.
module tb_booth_seq_ctrl;

    localparam int D = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [D-1:0]   M;
    logic [D-1:0]   Q;
    logic           busy;
    logic           done;
    logic [2*D-1:0] Product;

    int n_vec  = 0;
    int n_fail = 0;

    booth_seq_ctrl #(.D_SIZE(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .M       (M),
        .Q       (Q),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer product truncated to 2*D bits.
    function automatic logic [2*D-1:0] model(input logic [D-1:0] m, input logic [D-1:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[2*D-1:0];
    endfunction

    // One full operation from the start edge to the first IDLE cycle after done.
    // scramble: randomize M/Q/start every CALC cycle. poke_k: pulse start with 7x7
    // after CALC edge poke_k (0 = never).
    task automatic run_op(input logic [D-1:0] m, input logic [D-1:0] q,
                          input bit scramble, input int poke_k);
        logic [2*D-1:0] exp;
        int dones;
        exp   = model(m, q);
        M     = m;
        Q     = q;
        start = 1'b1;
        tick();
        check("busy_at_t0", 32'(busy), 32'd1);
        check("done_at_t0", 32'(done), 32'd0);
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= D; k++) begin
            if (scramble) begin
                M     = D'($urandom);
                Q     = D'($urandom);
                start = 1'($urandom);
            end else if (k == poke_k) begin
                M     = D'(7);
                Q     = D'(7);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            dones += int'(done);
            if (k < D) check("busy_calc", 32'(busy), 32'd1);
        end
        check("done_latency", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        check("product", 32'(Product), 32'(exp));
        start = 1'b0;
        tick();
        check("busy_after", 32'(busy), 32'd0);
        check("done_after", 32'(done), 32'd0);
        check("done_pulses", 32'(dones), 32'd1);
        check("product_held", 32'(Product), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        M     = '0;
        Q     = '0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(Product), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        run_op(4'b0101, 4'b0110, 1'b0, 0);
        run_op(4'b1100, 4'b0011, 1'b0, 0);
        run_op(4'b1101, 4'b1001, 1'b0, 0);
        run_op(4'b1001, 4'b0111, 1'b0, 0);
        run_op(4'b1000, 4'b1000, 1'b0, 0);
        run_op(4'b1000, 4'b0111, 1'b0, 0);
        run_op(4'b0000, 4'b1011, 1'b0, 0);
        run_op(4'b0110, 4'b0000, 1'b0, 0);

        // Second start during CALC must be ignored.
        run_op(4'd3, 4'd2, 1'b0, 2);

        // Back-to-back with start held high: one IDLE cycle between done and busy.
        M     = 4'd3;
        Q     = 4'd5;
        start = 1'b1;
        tick();
        for (int k = 1; k <= D; k++) tick();
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_prod1", 32'(Product), 32'(model(4'd3, 4'd5)));
        M = 4'hE;
        Q = 4'd3;
        tick();
        check("b2b_idle_gap", 32'(busy), 32'd0);
        tick();
        check("b2b_restart", 32'(busy), 32'd1);
        start = 1'b0;
        for (int k = 1; k <= D; k++) tick();
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_prod2", 32'(Product), 32'(model(4'hE, 4'd3)));
        tick();
        check("b2b_end", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of CALC.
        run_op(4'd3, 4'd2, 1'b0, 0);
        M     = 4'd7;
        Q     = 4'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_product", 32'(Product), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        run_op(4'd5, 4'd6, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_product", 32'(Product), 32'h1E);
            check("hold_busy", 32'(busy), 32'd0);
        end

        // Operands and start scrambled every CALC cycle.
        for (int i = 0; i < 40; i++) begin
            run_op(D'($urandom), D'($urandom), 1'b1, 0);
        end

        for (int a = 0; a < (1 << D); a++) begin
            for (int b = 0; b < (1 << D); b++) begin
                run_op(D'(a), D'(b), 1'b0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
